// File: rtl/instruction_decode.sv
// Instruction decode stage: captures one fetch word per DIR/ack_prev handshake,
// splits it into register fields, function code, extended immediate and class
// flags, and holds the bundle under DOR until the next stage acknowledges.
module instruction_decode #(
    parameter int unsigned ILLEGAL_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     DIR,
    input  logic [31:0]              data_in,
    output logic                     ack_prev,
    output logic                     DOR,
    input  logic                     ack_from_next,
    output logic [5:0]               opcode,
    output logic [4:0]               rd,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [5:0]               funct,
    output logic [31:0]              imm,
    output logic [2:0]               op_class,
    output logic                     illegal,
    output logic                     halt,
    output logic [ILLEGAL_CNT_W-1:0] illegal_count
);

    // FSM states
    localparam logic StIdle     = 1'b0;
    localparam logic StWaitNext = 1'b1;

    // Instruction classes
    localparam logic [2:0] ClsAlu    = 3'd0;
    localparam logic [2:0] ClsAlui   = 3'd1;
    localparam logic [2:0] ClsLoad   = 3'd2;
    localparam logic [2:0] ClsStore  = 3'd3;
    localparam logic [2:0] ClsBranch = 3'd4;
    localparam logic [2:0] ClsJump   = 3'd5;
    localparam logic [2:0] ClsLui    = 3'd6;
    localparam logic [2:0] ClsSys    = 3'd7;

    // Opcodes in the decode table
    localparam logic [5:0] OpAlu   = 6'h00;
    localparam logic [5:0] OpAlui  = 6'h01;
    localparam logic [5:0] OpLoad  = 6'h02;
    localparam logic [5:0] OpStore = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpJump  = 6'h06;
    localparam logic [5:0] OpLui   = 6'h07;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [ILLEGAL_CNT_W-1:0] CntOne = {{(ILLEGAL_CNT_W-1){1'b0}}, 1'b1};

    logic                     state_q;
    logic                     state_d;
    logic                     drop_seen_q;
    logic                     drop_seen_d;
    logic                     capture;
    logic                     dor_d;
    logic                     ack_d;
    logic                     cnt_sat;
    logic [ILLEGAL_CNT_W-1:0] cnt_d;

    logic [31:0] sext_imm;
    logic [2:0]  dec_class;
    logic [31:0] dec_imm;
    logic [5:0]  dec_funct;
    logic        dec_illegal;
    logic        dec_halt;

    assign sext_imm = {{16{data_in[15]}}, data_in[15:0]};

    // Capture only in IDLE, and only once DIR has dropped since the last capture
    assign capture = (state_q == StIdle) && DIR && drop_seen_q;

    // Combinational decode of the word currently on data_in
    always_comb begin
        dec_class   = ClsSys;
        dec_imm     = 32'h0;
        dec_funct   = 6'h0;
        dec_illegal = 1'b0;
        dec_halt    = 1'b0;
        case (data_in[31:26])
            OpAlu: begin
                dec_class = ClsAlu;
                dec_funct = data_in[5:0];
            end
            OpAlui: begin
                dec_class = ClsAlui;
                dec_imm   = sext_imm;
            end
            OpLoad: begin
                dec_class = ClsLoad;
                dec_imm   = sext_imm;
            end
            OpStore: begin
                dec_class = ClsStore;
                dec_imm   = sext_imm;
            end
            OpBeq, OpBne: begin
                dec_class = ClsBranch;
                dec_imm   = {sext_imm[29:0], 2'b00};
            end
            OpJump: begin
                dec_class = ClsJump;
                dec_imm   = {6'b0, data_in[25:0]};
            end
            OpLui: begin
                dec_class = ClsLui;
                dec_imm   = {data_in[15:0], 16'h0};
            end
            OpHalt: begin
                dec_class = ClsSys;
                dec_halt  = 1'b1;
            end
            default: begin
                dec_class   = ClsSys;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Handshake next-state: state, DOR, ack pulse and the DIR-drop tracker
    always_comb begin
        state_d     = state_q;
        dor_d       = DOR;
        ack_d       = 1'b0;
        drop_seen_d = drop_seen_q;
        case (state_q)
            StIdle: begin
                dor_d = capture;
                ack_d = capture;
                if (capture) begin
                    state_d = StWaitNext;
                end
            end
            StWaitNext: begin
                // A simultaneous new DIR is not looked at here; capture waits for IDLE
                if (ack_from_next) begin
                    dor_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                dor_d   = 1'b0;
            end
        endcase
        if (!DIR) begin
            drop_seen_d = 1'b1;
        end else if (capture) begin
            drop_seen_d = 1'b0;
        end
    end

    // Saturating illegal-word counter next value
    always_comb begin
        cnt_sat = &illegal_count;
        cnt_d   = illegal_count;
        if (capture && dec_illegal && !cnt_sat) begin
            cnt_d = illegal_count + CntOne;
        end
    end

    // Handshake and counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            drop_seen_q   <= 1'b1;
            DOR           <= 1'b0;
            ack_prev      <= 1'b0;
            illegal_count <= '0;
        end else begin
            state_q       <= state_d;
            drop_seen_q   <= drop_seen_d;
            DOR           <= dor_d;
            ack_prev      <= ack_d;
            illegal_count <= cnt_d;
        end
    end

    // Decoded bundle registers, loaded only on a capture edge and held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode   <= 6'h0;
            rd       <= 5'h0;
            rs       <= 5'h0;
            rt       <= 5'h0;
            funct    <= 6'h0;
            imm      <= 32'h0;
            op_class <= 3'h0;
            illegal  <= 1'b0;
            halt     <= 1'b0;
        end else if (capture) begin
            opcode   <= data_in[31:26];
            rd       <= data_in[25:21];
            rs       <= data_in[20:16];
            rt       <= data_in[15:11];
            funct    <= dec_funct;
            imm      <= dec_imm;
            op_class <= dec_class;
            illegal  <= dec_illegal;
            halt     <= dec_halt;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios followed by a
// randomized fetch-style upstream and stalling downstream, checked against a
// transaction-level reference model.
module tb_instruction_decode;

    localparam int unsigned CntW   = 8;
    localparam int          CntMax = (1 << CntW) - 1;
    localparam int          NRand  = 150;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            DIR = 1'b0;
    logic [31:0]     data_in = 32'h0;
    logic            ack_prev;
    logic            DOR;
    logic            ack_from_next = 1'b0;
    logic [5:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [5:0]      funct;
    logic [31:0]     imm;
    logic [2:0]      op_class;
    logic            illegal;
    logic            halt;
    logic [CntW-1:0] illegal_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    instruction_decode #(.ILLEGAL_CNT_W(CntW)) dut (
        .clk           (clk),
        .reset         (reset),
        .DIR           (DIR),
        .data_in       (data_in),
        .ack_prev      (ack_prev),
        .DOR           (DOR),
        .ack_from_next (ack_from_next),
        .opcode        (opcode),
        .rd            (rd),
        .rs            (rs),
        .rt            (rt),
        .funct         (funct),
        .imm           (imm),
        .op_class      (op_class),
        .illegal       (illegal),
        .halt          (halt),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cls;
        logic [31:0] imm;
        logic [5:0]  funct;
        logic        ill;
        logic        hlt;
    } ref_t;

    // Reference decode straight from the opcode table, using integer arithmetic
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        int   op;
        int   s16;
        op    = int'(w[31:26]);
        s16   = int'($signed(w[15:0]));
        r     = '0;
        r.cls = 3'd7;
        case (op)
            0:       begin r.cls = 3'd0; r.funct = w[5:0]; end
            1:       begin r.cls = 3'd1; r.imm = s16; end
            2:       begin r.cls = 3'd2; r.imm = s16; end
            3:       begin r.cls = 3'd3; r.imm = s16; end
            4, 5:    begin r.cls = 3'd4; r.imm = s16 * 4; end
            6:       begin r.cls = 3'd5; r.imm = w & 32'h03FF_FFFF; end
            7:       begin r.cls = 3'd6; r.imm = 32'(w[15:0]) * 32'd65536; end
            63:      r.hlt = 1'b1;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model side of a capture: update the expected saturating illegal count
    task automatic note_capture(input logic [31:0] w);
        ref_t r;
        r = ref_decode(w);
        if (r.ill && exp_cnt < CntMax) exp_cnt++;
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] w);
        ref_t r;
        r = ref_decode(w);
        check({tag, ".fields"}, 32'({opcode, rd, rs, rt}), 32'(w[31:11]));
        check({tag, ".imm"}, imm, r.imm);
        check({tag, ".cls"}, 32'({op_class, illegal, halt, funct}),
              32'({r.cls, r.ill, r.hlt, r.funct}));
    endtask

    // Present a word from IDLE; expect ack and DOR exactly one edge later
    task automatic capture(input string tag, input logic [31:0] w);
        DIR           = 1'b1;
        data_in       = w;
        ack_from_next = 1'b0;
        tick();
        note_capture(w);
        check({tag, ".ack"}, 32'(ack_prev), 32'd1);
        check({tag, ".dor"}, 32'(DOR), 32'd1);
        check_bundle(tag, w);
        check({tag, ".cnt"}, 32'(illegal_count), 32'(exp_cnt));
    endtask

    task automatic release_bundle(input string tag);
        DIR           = 1'b0;
        ack_from_next = 1'b1;
        tick();
        check({tag, ".ack_pulse"}, 32'(ack_prev), 32'd0);
        check({tag, ".dor_drop"}, 32'(DOR), 32'd0);
        ack_from_next = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        int op;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 7)      op = sel;
        else if (sel == 8) op = 63;
        else               op = $urandom_range(8, 62);
        return {6'(op), 26'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] cur_word;
        logic        out_q;
        logic        out_before;
        logic        dir_b;
        logic        ackn_b;
        logic        exp_ack;
        int          sent;
        int          gap;

        // Power-on reset
        #2 reset = 1'b0;
        #10;
        check("rst.dor", 32'(DOR), 32'd0);
        check("rst.ack", 32'(ack_prev), 32'd0);
        check("rst.imm", imm, 32'd0);
        check("rst.bundle", 32'({opcode, rd, rs, rt, funct, op_class, illegal, halt}), 32'd0);
        check("rst.cnt", 32'(illegal_count), 32'd0);
        @(negedge clk) reset = 1'b1;

        // LOAD with negative offset
        capture("load", 32'h0862_FFF8);
        check("load.class", 32'(op_class), 32'd2);
        check("load.rd", 32'(rd), 32'd3);
        check("load.rs", 32'(rs), 32'd2);
        check("load.immv", imm, 32'hFFFF_FFF8);
        release_bundle("load");

        // Branch, LUI and JUMP immediates
        capture("beq", 32'h1000_0004);
        check("beq.class", 32'(op_class), 32'd4);
        check("beq.immv", imm, 32'h0000_0010);
        release_bundle("beq");
        capture("lui", 32'h1C00_1234);
        check("lui.class", 32'(op_class), 32'd6);
        check("lui.immv", imm, 32'h1234_0000);
        release_bundle("lui");
        capture("jump", 32'h18AB_CDEF);
        check("jump.class", 32'(op_class), 32'd5);
        check("jump.immv", imm, 32'h00AB_CDEF);
        release_bundle("jump");
        capture("alu", 32'h0043_1825);
        check("alu.funct", 32'(funct), 32'h25);
        release_bundle("alu");

        // Stalled downstream with DIR held high
        w = 32'h0C85_0100;
        capture("stall", w);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall.ack", 32'(ack_prev), 32'd0);
            check("stall.dor", 32'(DOR), 32'd1);
            check_bundle("stall.hold", w);
        end
        ack_from_next = 1'b1;
        tick();
        check("stall.release", 32'(DOR), 32'd0);
        check("stall.rel_ack", 32'(ack_prev), 32'd0);
        // DIR never dropped, so the same word must not be recaptured; IDLE ack ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nodup.ack", 32'(ack_prev), 32'd0);
            check("nodup.dor", 32'(DOR), 32'd0);
            check_bundle("nodup.hold", w);
        end
        ack_from_next = 1'b0;
        DIR           = 1'b0;
        tick();

        // New word offered on the same edge as the downstream ack
        capture("sim1", 32'h0422_0007);
        DIR = 1'b0;
        tick();
        check("sim.gap_dor", 32'(DOR), 32'd1);
        w             = 32'h1400_FFFF;
        DIR           = 1'b1;
        data_in       = w;
        ack_from_next = 1'b1;
        tick();
        check("sim.rel_dor", 32'(DOR), 32'd0);
        check("sim.rel_ack", 32'(ack_prev), 32'd0);
        ack_from_next = 1'b0;
        tick();
        note_capture(w);
        check("sim.cap_ack", 32'(ack_prev), 32'd1);
        check("sim.cap_dor", 32'(DOR), 32'd1);
        check_bundle("sim2", w);
        release_bundle("sim2");

        // Illegal opcode repeated until the counter saturates, then HALT
        for (int i = 0; i < 300; i++) begin
            w = {6'h20, 26'($urandom)};
            capture("ill", w);
            check("ill.flag", 32'(illegal), 32'd1);
            release_bundle("ill");
        end
        check("ill.sat", 32'(illegal_count), 32'hFF);
        capture("halt", 32'hFC00_0000);
        check("halt.flag", 32'(halt), 32'd1);
        check("halt.ill", 32'(illegal), 32'd0);
        check("halt.cnt", 32'(illegal_count), 32'hFF);

        // Reset asserted while the halt bundle is waiting downstream
        reset = 1'b0;
        #1;
        check("arst.dor", 32'(DOR), 32'd0);
        check("arst.ack", 32'(ack_prev), 32'd0);
        check("arst.imm_halt", 32'({imm, halt}), 32'd0);
        check("arst.cnt", 32'(illegal_count), 32'd0);
        exp_cnt = 0;
        DIR     = 1'b0;
        tick();
        check("arst.hold_dor", 32'(DOR), 32'd0);
        @(negedge clk) reset = 1'b1;
        capture("after_rst", 32'h0862_FFF8);
        release_bundle("after_rst");

        // Randomized fetch-style upstream against a randomly stalling downstream
        out_q    = 1'b0;
        sent     = 0;
        gap      = 1;
        cur_word = 32'h0;
        w        = rand_word();
        for (int cyc = 0; cyc < 5000 && sent < NRand; cyc++) begin
            if (gap > 0) begin
                DIR = 1'b0;
                gap--;
            end else begin
                DIR     = 1'b1;
                data_in = w;
            end
            ack_from_next = ($urandom_range(0, 2) == 0);
            dir_b      = DIR;
            ackn_b     = ack_from_next;
            out_before = out_q;
            tick();
            // Take a word only when nothing is outstanding; release on an accepted ack
            exp_ack = dir_b && !out_before;
            if (exp_ack) begin
                out_q    = 1'b1;
                cur_word = w;
                note_capture(w);
                sent++;
                gap = $urandom_range(1, 3);
                w   = rand_word();
            end else if (out_before && ackn_b) begin
                out_q = 1'b0;
            end
            check("rand.ack", 32'(ack_prev), 32'(exp_ack));
            check("rand.dor", 32'(DOR), 32'(out_q));
            check("rand.cnt", 32'(illegal_count), 32'(exp_cnt));
            if (out_q) check_bundle("rand", cur_word);
        end
        check("rand.sent", 32'(sent), 32'(NRand));
        DIR           = 1'b0;
        ack_from_next = 1'b1;
        tick();
        check("rand.drain", 32'(DOR), 32'd0);
        ack_from_next = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
